// File: rtl/arrow_ctrl_if.sv
// Pixel-timing, button and arrow-control signals shared between the timing/input side and arrow_ctrl.
interface arrow_ctrl_if;
  logic       pixelEN;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       btn_up;
  logic       btn_down;
  logic       btn_sel;
  logic       romEN;
  logic       isarrow;
  logic       movearrow;
  logic [1:0] item;
  logic       select_pulse;

  modport master (
    output pixelEN, hcount, vcount, btn_up, btn_down, btn_sel,
    input  romEN, isarrow, movearrow, item, select_pulse
  );

  modport slave (
    input  pixelEN, hcount, vcount, btn_up, btn_down, btn_sel,
    output romEN, isarrow, movearrow, item, select_pulse
  );
endinterface

// File: rtl/arrow_ctrl.sv
// Menu-cursor controller: debounced up/down/select, cursor moves committed at vblank start.
// romEN/isarrow lag hcount/vcount by one pixelEN; movearrow/select_pulse are single-cycle pulses.
module arrow_ctrl #(
  parameter int ARROW_X         = 200,
  parameter int ITEM_Y0         = 150,
  parameter int ITEM_PITCH      = 60,
  parameter int NUM_ITEMS       = 4,
  parameter int ARROW_W         = 30,
  parameter int ARROW_H         = 30,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        vgaclk,
  input  logic        reset,
  arrow_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_VB, COMMIT, SELECTED} state_t;

  localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]  LAST_ITEM = 2'(NUM_ITEMS - 1);

  logic [2:0]  sync1, sync2, deb, deb_d, press;
  logic [19:0] cnt [3];
  state_t      state, state_nxt;
  logic [1:0]  item_q, pending, pending_nxt;
  logic        move_up, move_down, sel_press;
  logic        sel_pulse, mv_pulse, vblank_start;
  logic [10:0] hpos, vpos, ytop;
  logic        in_active, in_box;
  logic        rom_q, arrow_q;

  function automatic logic [1:0] step_up(input logic [1:0] x);
    return (x == 2'd0) ? LAST_ITEM : x - 2'd1;
  endfunction

  function automatic logic [1:0] step_down(input logic [1:0] x);
    return (x == LAST_ITEM) ? 2'd0 : x + 2'd1;
  endfunction

  // Bit order in the button vectors: 0 = up, 1 = down, 2 = select.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {bus.btn_sel, bus.btn_down, bus.btn_up};
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 20'd1;
        end
      end
    end
  end

  assign press     = deb & ~deb_d;
  assign move_up   = press[0] & ~press[1];
  assign move_down = press[1] & ~press[0];
  assign sel_press = press[2];

  assign vblank_start = bus.pixelEN && (bus.hcount == 10'd0) && (bus.vcount == 10'(V_ACTIVE));

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    sel_pulse   = 1'b0;
    mv_pulse    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_press) begin
          sel_pulse = 1'b1;
          state_nxt = SELECTED;
        end else if (move_up) begin
          pending_nxt = step_up(item_q);
          state_nxt   = WAIT_VB;
        end else if (move_down) begin
          pending_nxt = step_down(item_q);
          state_nxt   = WAIT_VB;
        end
      end
      WAIT_VB: begin
        if (move_up)        pending_nxt = step_up(pending);
        else if (move_down) pending_nxt = step_down(pending);
        if (vblank_start) state_nxt = COMMIT;
      end
      COMMIT: begin
        mv_pulse  = 1'b1;
        state_nxt = IDLE;
      end
      SELECTED: begin
        if (!deb[2]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      item_q  <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (state == COMMIT) item_q <= pending;
    end
  end

  // item only changes right after vblank_start, so the box position is fixed for a whole frame.
  assign hpos      = {1'b0, bus.hcount};
  assign vpos      = {1'b0, bus.vcount};
  assign ytop      = 11'(ITEM_Y0) + 11'(item_q) * 11'(ITEM_PITCH);
  assign in_active = (hpos < 11'(H_ACTIVE)) && (vpos < 11'(V_ACTIVE));
  assign in_box    = in_active
                  && (hpos >= 11'(ARROW_X)) && (hpos <= 11'(ARROW_X + ARROW_W - 1))
                  && (vpos >= ytop) && (vpos <= ytop + 11'(ARROW_H - 1));

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      rom_q   <= 1'b0;
      arrow_q <= 1'b0;
    end else if (bus.pixelEN) begin
      rom_q   <= in_active;
      arrow_q <= in_box;
    end
  end

  assign bus.romEN        = rom_q;
  assign bus.isarrow      = arrow_q;
  assign bus.movearrow    = mv_pulse;
  assign bus.select_pulse = sel_pulse;
  assign bus.item         = item_q;

endmodule

// File: doc/arrow_ctrl.md
Name: arrow_ctrl

Overview:
Menu-cursor controller that sits directly upstream of the arrow overlay stage. It debounces the up/down/select buttons and holds the selected menu item (0..NUM_ITEMS-1). Cursor moves are deferred to the start of vertical blank so a frame never tears. Each pixel it generates the romEN, isarrow and movearrow controls that the overlay stage consumes.

Parameters:
ARROW_X, 200, left column of the arrow box (pixels)
ITEM_Y0, 150, top row of the arrow box for item 0
ITEM_PITCH, 60, vertical distance between items (rows)
NUM_ITEMS, 4, number of menu items (2..4)
ARROW_W, 30, arrow box width; ARROW_W*ARROW_H must equal the overlay bitmap size (900)
ARROW_H, 30, arrow box height
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible rows
DEBOUNCE_CYCLES, 500000, consecutive stable vgaclk samples required to accept a button level (20 bits)

Ports:
vgaclk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
pixelEN  in  1  one-cycle pixel strobe from the timing generator
hcount  in  10  current pixel column, valid on pixelEN
vcount  in  10  current pixel row, valid on pixelEN
btn_up  in  1  raw, asynchronous, active-high button
btn_down  in  1  raw, asynchronous, active-high button
btn_sel  in  1  raw, asynchronous, active-high button
romEN  out  1  registered; visible-area flag
isarrow  out  1  registered; pixel lies inside the arrow box
movearrow  out  1  one-vgaclk pulse when the cursor position commits
item  out  2  committed menu item
select_pulse  out  1  one-vgaclk pulse on a select press

Behaviour:
- Reset (async assert): item=0, pending=0, state=IDLE, romEN=isarrow=movearrow=select_pulse=0, all debounce counters=0, debounced levels=0, synchronizers=0.
- Input conditioning: 2-FF synchronizer per button. Each button has its own counter.
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments. At DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - A press event is a 0->1 transition of the debounced level, one cycle wide.
- Pixel outputs: update only on cycles with pixelEN=1 and hold otherwise. Latency is one pixelEN from hcount/vcount.
  - romEN <= (hcount<H_ACTIVE) && (vcount<V_ACTIVE).
  - isarrow <= hcount in [ARROW_X, ARROW_X+ARROW_W-1] and vcount in [Y, Y+ARROW_H-1], where Y = ITEM_Y0 + item*ITEM_PITCH (11-bit arithmetic, no wrap).
  - isarrow implies romEN. The box is exactly ARROW_W*ARROW_H pixels per frame.
- vblank_start = pixelEN && hcount==0 && vcount==V_ACTIVE.
- FSM states: IDLE, WAIT_VB, COMMIT, SELECTED.
  - IDLE, up press: pending=(item==0 ? NUM_ITEMS-1 : item-1); go to WAIT_VB.
  - IDLE, down press: pending=(item==NUM_ITEMS-1 ? 0 : item+1); go to WAIT_VB.
  - Up and down press events in the same cycle: ignored in every state.
  - IDLE, sel press: select_pulse=1 for one cycle; go to SELECTED. If sel coincides with up/down, sel wins and the move is dropped.
  - WAIT_VB, further up/down press: step pending again from pending, with wrap. Sel is ignored.
  - WAIT_VB, vblank_start: go to COMMIT.
  - COMMIT (one cycle): item<=pending; movearrow=1 this cycle only; then IDLE.
  - SELECTED: up/down ignored; return to IDLE when the debounced sel level is 0.
- item changes only in COMMIT, so isarrow is never split across a frame.
- Reset mid-frame or mid-debounce: immediate return to reset values. The first frame after release starts with romEN/isarrow from the first pixelEN.

Test Plan:
(Bench overrides DEBOUNCE_CYCLES=4, timing generator 800x525 with pixelEN every 2nd cycle.)
- Reset, no buttons, one full frame -> item=0, exactly 900 pixelEN cycles with isarrow=1, all at hcount 200..229 and vcount 150..179; movearrow never asserted.
- Down held 10 cycles mid-frame -> no change until vblank_start; COMMIT follows; movearrow high exactly 1 cycle; item=1; next frame isarrow rows 210..239.
- Up pressed at item=0 -> item=3 after vblank; two down presses in the same frame from item=3 -> single commit, item=1, one movearrow pulse.
- btn_down glitch of 2 cycles -> no press event, item unchanged; up+down debounced in the same cycle -> ignored.
- Sel press -> select_pulse 1 cycle; down pressed while sel still held -> ignored; sel released then down -> normal move.
- Async reset asserted while in WAIT_VB with pending=2 -> outputs 0 immediately; after release item=0 and no movearrow pulse.
